lcd_ydrive_seq: RTL and testbench



---
 rtl/lcd_ydrive_if.sv | 12 +
 rtl/lcd_ydrive_seq.sv | 85 ++++++++
 tb/tb_lcd_ydrive_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lcd_ydrive_if.sv
// lcd_ydrive_if: enable input and timing outputs of the LCD Y-driver sequencer
interface lcd_ydrive_if;
    logic       en;
    logic       CPL;
    logic       S;
    logic       FR;
    logic [7:0] line;
    logic       vblank;
    logic       frame_start;
    modport master (input en, output CPL, S, FR, line, vblank, frame_start);
    modport slave (output en, input CPL, S, FR, line, vblank, frame_start);
endinterface

// File: rtl/lcd_ydrive_seq.sv
// lcd_ydrive_seq: line clock, frame start and polarity sequencer for the LCD row driver
// LCD_FR_LINE_INV_EN selects line inversion of FR; otherwise FR inverts once per frame.
module lcd_ydrive_seq #(
    parameter int LINE_CYCLES   = 456,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154,
    parameter int CPL_WIDTH     = 4
) (
    input logic clk,
    input logic rst,
    lcd_ydrive_if.master bus
);
    localparam int DW = LINE_CYCLES > 1 ? $clog2(LINE_CYCLES) : 1;
    localparam int LW = TOTAL_LINES > 1 ? $clog2(TOTAL_LINES) : 1;
    localparam logic [DW-1:0] DOT_LAST  = DW'(LINE_CYCLES - 1);
    localparam logic [DW-1:0] CPL_END   = DW'(CPL_WIDTH);
    localparam logic [LW-1:0] LINE_LAST = LW'(TOTAL_LINES - 1);
    localparam logic [LW-1:0] VIS_LAST  = LW'(VISIBLE_LINES - 1);

    typedef enum logic [1:0] {OFF, ACTIVE, VBLANK} state_t;

    state_t state_q, state_d;
    logic [DW-1:0] dot_q, dot_d;
    logic [LW-1:0] line_q, line_d;
    logic cpl_q, cpl_d, s_q, s_d, fr_q, fr_d, vblank_q, vblank_d, fs_q, fs_d;
    logic dot_wrap, line_wrap, fr_toggle, on;

    // Outputs are derived from next-state counters so they move on the same edge.
    always_comb begin
        dot_wrap  = dot_q == DOT_LAST;
        line_wrap = dot_wrap && line_q == LINE_LAST;
`ifdef LCD_FR_LINE_INV_EN
        fr_toggle = dot_wrap;
`else
        fr_toggle = line_wrap;
`endif
        state_d = state_q;
        dot_d   = '0;
        line_d  = '0;
        fr_d    = 1'b0;
        if (!bus.en) state_d = OFF;
        else if (state_q == OFF) state_d = ACTIVE;
        else begin
            dot_d  = dot_wrap ? '0 : dot_q + DW'(1);
            line_d = line_wrap ? '0 : line_q + LW'(dot_wrap);
            fr_d   = fr_q ^ fr_toggle;
            if (line_wrap) state_d = ACTIVE;
            else if (dot_wrap && line_q == VIS_LAST) state_d = VBLANK;
        end
        on       = state_d != OFF;
        cpl_d    = on && dot_d < CPL_END;
        s_d      = on && line_d == '0 && dot_d <= CPL_END;
        fs_d     = on && line_d == '0 && dot_d == '0;
        vblank_d = state_d == VBLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OFF;
            dot_q    <= '0;
            line_q   <= '0;
            cpl_q    <= 1'b0;
            s_q      <= 1'b0;
            fr_q     <= 1'b0;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dot_q    <= dot_d;
            line_q   <= line_d;
            cpl_q    <= cpl_d;
            s_q      <= s_d;
            fr_q     <= fr_d;
            vblank_q <= vblank_d;
            fs_q     <= fs_d;
        end
    end

    assign bus.CPL         = cpl_q;
    assign bus.S           = s_q;
    assign bus.FR          = fr_q;
    assign bus.line        = 8'(line_q);
    assign bus.vblank      = vblank_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_lcd_ydrive_seq.sv
// tb_lcd_ydrive_seq: vector table plus time-since-enable reference model for lcd_ydrive_seq
module tb_lcd_ydrive_seq;
    localparam int LC = 10, VIS = 3, TL = 5, CW = 3, FL = LC * TL;

    typedef logic [12:0] obs_t; // {CPL, S, FR, vblank, frame_start, line[7:0]}
    typedef struct {
        logic rst;
        logic en;
        obs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    lcd_ydrive_if bus();

    lcd_ydrive_seq #(.LINE_CYCLES(LC), .VISIBLE_LINES(VIS), .TOTAL_LINES(TL), .CPL_WIDTH(CW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    obs_t q[$];
    int total = 0, bad = 0;
    bit run = 1'b0;
    int t = 0;

    function automatic obs_t mk(input logic c, s, f, v, fs, input int ln);
        logic [7:0] l;
        l = 8'(ln);
        return {c, s, f, v, fs, l};
    endfunction

    // Expected outputs after one edge, from cycles elapsed since enable.
    function automatic obs_t model(input logic r, e);
        int dot, ln, fr;
        if (r || !e) begin
            run = 1'b0;
            t = 0;
        end else if (!run) begin
            run = 1'b1;
            t = 0;
        end else t++;
        if (!run) return '0;
        dot = t % LC;
        ln = (t / LC) % TL;
`ifdef LCD_FR_LINE_INV_EN
        fr = (t / LC) % 2;
`else
        fr = (t / FL) % 2;
`endif
        return mk(dot < CW, ln == 0 && dot <= CW, fr[0], ln >= VIS, ln == 0 && dot == 0, ln);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, e, input string name, output obs_t got);
        @(negedge clk);
        rst = r;
        bus.en = e;
        q.push_back(model(r, e));
        @(posedge clk);
        #1;
        got = {bus.CPL, bus.S, bus.FR, bus.vblank, bus.frame_start, bus.line};
        check(name, int'(got), int'(q.pop_front()));
    endtask

    initial begin
        vec_t vecs[14];
        obs_t got;
        int last_fs, cpl_cnt, cyc;
        logic prev_cpl;
        bus.en = 1'b0;
        vecs[0]  = '{1'b1, 1'b0, '0};
        vecs[1]  = '{1'b1, 1'b1, '0};
        vecs[2]  = '{1'b1, 1'b1, '0};
        vecs[3]  = '{1'b0, 1'b1, mk(1, 1, 0, 0, 1, 0)};
        vecs[4]  = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0)};
        vecs[5]  = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0)};
        vecs[6]  = '{1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0)};
        vecs[7]  = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{1'b1, 1'b1, '0};
        vecs[9]  = '{1'b0, 1'b1, mk(1, 1, 0, 0, 1, 0)};
        vecs[10] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0)};
        vecs[11] = '{1'b0, 1'b0, '0};
        vecs[12] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 1, 0)};
        vecs[13] = '{1'b0, 1'b1, mk(1, 1, 0, 0, 0, 0)};
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].en, $sformatf("vec%0d_model", i), got);
            check($sformatf("vec%0d_table", i), int'(got), int'(vecs[i].exp));
        end
        // Three full frames from a fresh enable: spacing and CPL count.
        step(1'b1, 1'b0, "pre_run_reset", got);
        last_fs = -1;
        cpl_cnt = 0;
        prev_cpl = 1'b0;
        for (cyc = 0; cyc < 3 * FL + 5; cyc++) begin
            step(1'b0, 1'b1, "run", got);
            if (got[8]) begin
                if (last_fs >= 0) begin
                    check("frame_len", cyc - last_fs, FL);
                    check("cpl_per_frame", cpl_cnt, TL);
                end
                last_fs = cyc;
                cpl_cnt = 0;
            end
            if (got[12] && !prev_cpl) cpl_cnt++;
            prev_cpl = got[12];
        end
        check("frames_seen", last_fs, 3 * FL);
        // Drop en while mid-CPL at dot 2 of line 2.
        for (int i = 0; i < 2 * FL && !(run && t % FL == 2 * LC + 2); i++) step(1'b0, 1'b1, "seek_cpl", got);
        check("seek_cpl_reached", int'(run && t % FL == 2 * LC + 2), 1);
        step(1'b0, 1'b0, "disable_mid_cpl", got);
        check("disable_all_zero", int'(got), 0);
        step(1'b0, 1'b1, "reenable", got);
        check("reenable_restart", int'(got), int'(mk(1, 1, 0, 0, 1, 0)));
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "after_reenable", got);
        step(1'b0, 1'b0, "toggle_off", got);
        check("toggle_off_zero", int'(got), 0);
        step(1'b0, 1'b1, "toggle_on", got);
        check("toggle_restart", int'(got), int'(mk(1, 1, 0, 0, 1, 0)));
        // Reset during vblank with en held high.
        for (int i = 0; i < 2 * FL && !(run && t % FL == 4 * LC + 5); i++) step(1'b0, 1'b1, "seek_vblank", got);
        check("vblank_before_reset", int'(bus.vblank), 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, "mid_reset", got);
            check("mid_reset_zero", int'(got), 0);
        end
        step(1'b0, 1'b1, "post_reset", got);
        check("post_reset_restart", int'(got), int'(mk(1, 1, 0, 0, 1, 0)));
        for (int i = 0; i < FL + 3; i++) step(1'b0, 1'b1, "tail", got);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
